// File: rtl/div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_ctrl_pkg
// Shared definitions for the multi-cycle divide sequencer:
//   - div_state_e : FSM state encoding (DIV_IDLE, DIV_RUN, DIV_ZERO, DIV_FIX,
//                   DIV_DONE)
//   - cond_neg    : conditional two's-complement negate, modulo 2^32
// -----------------------------------------------------------------------------
package div_ctrl_pkg;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_RUN  = 3'd1,
    DIV_ZERO = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_e;

  // Negate when neg is set; the magnitude of 0x80000000 is itself, which is
  // exactly what the unsigned datapath needs.
  function automatic logic [31:0] cond_neg(input logic neg, input logic [31:0] val);
    logic [31:0] res;
    if (neg) begin
      res = 32'd0 - val;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/div_ctrl_step.sv
// -----------------------------------------------------------------------------
// div_ctrl_step
// One restoring-division iteration (the div_step stage), purely combinational.
// Ports:
//   i_rq  in  2*WIDTH  partial remainder/quotient pair {r,q}
//   i_d   in  WIDTH    divisor magnitude
//   o_rq  out 2*WIDTH  {r,q} after one shift-and-trial-subtract
// -----------------------------------------------------------------------------
module div_ctrl_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_rq,
  input  logic [WIDTH-1:0]   i_d,
  output logic [2*WIDTH-1:0] o_rq
);

  // Shifted remainder needs one extra bit: 2r+1 can exceed WIDTH bits.
  logic [WIDTH:0]   w_rs;
  logic [WIDTH+1:0] w_diff;
  logic             w_unused;

  assign w_rs   = i_rq[2*WIDTH-1:WIDTH-1];
  assign w_diff = {1'b0, w_rs} - {2'b00, i_d};

  // When the trial succeeds the difference is < d, and when it fails the
  // shifted remainder is < d, so the dropped top bits are always zero.
  assign w_unused = w_diff[WIDTH] ^ w_rs[WIDTH];

  // Keep the trial difference when non-negative, else restore.
  always_comb begin
    o_rq = i_rq;
    if (!w_diff[WIDTH+1]) begin
      o_rq = {w_diff[WIDTH-1:0], i_rq[WIDTH-2:0], 1'b1};
    end else begin
      o_rq = {w_rs[WIDTH-1:0], i_rq[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Multi-cycle DIV/DIVU sequencer for the EX stage. Runs a WIDTH-iteration
// restoring division, stalls IF..EX until the quotient/remainder is ready for
// the HI/LO write, and abandons the operation on a pipeline flush.
// Ports:
//   clk         in   clock, rising edge
//   resetn      in   asynchronous active-low reset
//   start       in   EX holds DIV/DIVU (level)
//   signed_div  in   1 = DIV, 0 = DIVU (sampled at accept)
//   flush       in   exception/eret flush, aborts the operation
//   opa, opb    in   dividend / divisor (sampled at accept)
//   stall       out  freeze IF..EX
//   ready       out  one-cycle pulse, results valid
//   result_lo   out  quotient  -> LO
//   result_hi   out  remainder -> HI
//   div_zero    out  completed operation had a zero divisor
// -----------------------------------------------------------------------------
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic             flush,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             stall,
  output logic             ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e         r_state;
  div_state_e         w_fsm_next;
  div_state_e         w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_rq;
  logic [2*WIDTH-1:0] w_rq_next;
  logic [WIDTH-1:0]   r_d;
  logic [WIDTH-1:0]   r_opa;
  logic               r_qneg;
  logic               r_rneg;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic               r_dz;

  logic               w_accept;
  logic               w_opa_neg;
  logic               w_opb_neg;
  logic [WIDTH-1:0]   w_opa_mag;
  logic [WIDTH-1:0]   w_opb_mag;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;

  assign w_accept  = (r_state == DIV_IDLE) & start & ~flush;
  assign w_opa_neg = signed_div & opa[WIDTH-1];
  assign w_opb_neg = signed_div & opb[WIDTH-1];
  assign w_opa_mag = cond_neg(w_opa_neg, opa);
  assign w_opb_mag = cond_neg(w_opb_neg, opb);
  assign w_r       = r_rq[2*WIDTH-1:WIDTH];
  assign w_q       = r_rq[WIDTH-1:0];

  div_ctrl_step #(.WIDTH(WIDTH)) u_step (
    .i_rq (r_rq),
    .i_d  (r_d),
    .o_rq (w_rq_next)
  );

  // Next-state decode; flush overrides everything and returns to IDLE.
  always_comb begin
    w_fsm_next = r_state;
    case (r_state)
      DIV_IDLE: begin
        if (w_accept) begin
          w_fsm_next = (opb == '0) ? DIV_ZERO : DIV_RUN;
        end else begin
          w_fsm_next = DIV_IDLE;
        end
      end
      DIV_RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_fsm_next = DIV_FIX;
        end else begin
          w_fsm_next = DIV_RUN;
        end
      end
      DIV_ZERO: w_fsm_next = DIV_DONE;
      DIV_FIX:  w_fsm_next = DIV_DONE;
      DIV_DONE: w_fsm_next = DIV_IDLE;
      default:  w_fsm_next = DIV_IDLE;
    endcase
  end

  assign w_next = flush ? DIV_IDLE : w_fsm_next;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operand latch at accept and one iteration per RUN cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt  <= '0;
      r_rq   <= '0;
      r_d    <= '0;
      r_opa  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (w_accept) begin
            r_cnt  <= '0;
            r_rq   <= {{WIDTH{1'b0}}, w_opa_mag};
            r_d    <= w_opb_mag;
            r_opa  <= opa;
            r_qneg <= w_opa_neg ^ w_opb_neg;
            r_rneg <= w_opa_neg;
          end
        end
        DIV_RUN: begin
          r_rq  <= w_rq_next;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers; only a non-flushed FIX or ZERO cycle updates them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lo <= '0;
      r_hi <= '0;
      r_dz <= 1'b0;
    end else if (!flush) begin
      case (r_state)
        DIV_FIX: begin
          r_lo <= cond_neg(r_qneg, w_q);
          r_hi <= cond_neg(r_rneg, w_r);
          r_dz <= 1'b0;
        end
        DIV_ZERO: begin
          r_lo <= '1;
          r_hi <= r_opa;
          r_dz <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Stall is combinational only through the accept term in IDLE.
  assign stall = (r_state == DIV_RUN) | (r_state == DIV_ZERO) |
                 (r_state == DIV_FIX) | w_accept;

  assign ready     = (r_state == DIV_DONE);
  assign result_lo = r_lo;
  assign result_hi = r_hi;
  assign div_zero  = r_dz;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] opa = 32'd0;
  logic [31:0] opb = 32'd0;
  logic        stall;
  logic        ready;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        div_zero;

  int total = 0;
  int bad = 0;

  div_ctrl #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .flush      (flush),
    .opa        (opa),
    .opb        (opb),
    .stall      (stall),
    .ready      (ready),
    .result_lo  (result_lo),
    .result_hi  (result_hi),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #2;
    total++;
    if ({ready, stall, div_zero} !== 3'b000 || result_lo !== 32'd0 || result_hi !== 32'd0) begin
      bad++;
      $display("FAIL reset_state got rdy=%b stall=%b dz=%b lo=%h hi=%h want all 0",
               ready, stall, div_zero, result_lo, result_hi);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Issue one operation, wait for ready, check latency/stall/results.
  task automatic test_op(input string nm, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input logic exp_dz, input int exp_lat);
    int   n;
    logic got;
    logic stall_ok;
    @(negedge clk);
    start = 1'b1; signed_div = sg; opa = a; opb = b;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL %s_accept_stall got=%b want=1", nm, stall);
    end
    n = 0; got = 1'b0; stall_ok = 1'b1;
    while (!got && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) begin
        opa = 32'hDEADBEEF;   // operand changes after accept must be ignored
        opb = 32'd0;
        signed_div = ~sg;
      end
      if (ready === 1'b1) got = 1'b1;
      else if (stall !== 1'b1) stall_ok = 1'b0;
    end
    total++;
    if (!got || n != exp_lat) begin
      bad++;
      $display("FAIL %s_latency got=%0d (ready seen=%b) want=%0d", nm, n, got, exp_lat);
    end
    total++;
    if (!stall_ok || stall !== 1'b0) begin
      bad++;
      $display("FAIL %s_stall got busy_ok=%b done_stall=%b want 1/0", nm, stall_ok, stall);
    end
    total++;
    if (result_lo !== exp_lo || result_hi !== exp_hi || div_zero !== exp_dz) begin
      bad++;
      $display("FAIL %s_result got lo=%h hi=%h dz=%b want lo=%h hi=%h dz=%b",
               nm, result_lo, result_hi, div_zero, exp_lo, exp_hi, exp_dz);
    end
    start = 1'b0;
    @(negedge clk);
    total++;
    if (ready !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL %s_after got rdy=%b stall=%b want 0/0", nm, ready, stall);
    end
  endtask

  // Flush mid-RUN, then flush together with start in IDLE, then a fresh op.
  task automatic test_flush(input logic [31:0] prev_lo, input logic [31:0] prev_hi,
                            input logic prev_dz);
    int rdy_cnt;
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opa = 32'd100; opb = 32'd7;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    total++;
    if (ready !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle got rdy=%b stall=%b want 0/0", ready, stall);
    end
    total++;
    if (result_lo !== prev_lo || result_hi !== prev_hi || div_zero !== prev_dz) begin
      bad++;
      $display("FAIL flush_hold got lo=%h hi=%h dz=%b want lo=%h hi=%h dz=%b",
               result_lo, result_hi, div_zero, prev_lo, prev_hi, prev_dz);
    end
    start = 1'b1; flush = 1'b1; opa = 32'd50; opb = 32'd0;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL flush_start_stall got=%b want=0", stall);
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    rdy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready === 1'b1 || stall === 1'b1) rdy_cnt++;
    end
    total++;
    if (rdy_cnt != 0 || result_lo !== prev_lo || result_hi !== prev_hi) begin
      bad++;
      $display("FAIL flush_no_ready got busy_cycles=%0d lo=%h hi=%h want 0 lo=%h hi=%h",
               rdy_cnt, result_lo, result_hi, prev_lo, prev_hi);
    end
    test_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);
  endtask

  // Hold start through DONE with new operands: the next IDLE accepts them.
  task automatic test_back_to_back();
    int n;
    logic got;
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opa = 32'd100; opb = 32'd7;
    n = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (ready === 1'b1) got = 1'b1;
    end
    opa = 32'd1000; opb = 32'd9;
    n = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (ready === 1'b1) got = 1'b1;
    end
    total++;
    if (!got || n != 35 || result_lo !== 32'd111 || result_hi !== 32'd1) begin
      bad++;
      $display("FAIL b2b got n=%0d rdy=%b lo=%h hi=%h want n=35 lo=0000006f hi=00000001",
               n, got, result_lo, result_hi);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  // Asynchronous reset in the middle of an operation.
  task automatic test_reset_mid();
    int rdy_cnt;
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opa = 32'd100; opb = 32'd7;
    repeat (20) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    resetn = 1'b0;
    #1;
    total++;
    if ({ready, stall, div_zero} !== 3'b000 || result_lo !== 32'd0 || result_hi !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid got rdy=%b stall=%b dz=%b lo=%h hi=%h want all 0",
               ready, stall, div_zero, result_lo, result_hi);
    end
    @(negedge clk);
    resetn = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready === 1'b1 || stall === 1'b1) rdy_cnt++;
    end
    total++;
    if (rdy_cnt != 0) begin
      bad++;
      $display("FAIL reset_no_ready got busy_cycles=%0d want 0", rdy_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_op("divu_100_7", 1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34);
    test_op("div_m7_2",   1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 34);
    test_op("div_min_m1", 1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 34);
    test_op("div_7_m2",   1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 34);
    test_op("divu_max_1", 1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 34);
    test_op("divu_5_0",   1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 2);
    test_op("divu_big",   1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          32'd1,          1'b0, 34);
    test_op("div_m5_0",   1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1, 2);
    test_flush(32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1);
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
